// File: rtl/branch_predictor_bht_pkg.sv
// Shared constants for the branch history table: PC width, default table
// geometry and 2-bit counter encodings.
package branch_predictor_bht_pkg;

  localparam int unsigned PC_WIDTH    = 32;
  localparam int unsigned BHT_ENTRIES = 16;
  localparam int unsigned BHT_TAG_W   = 8;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

endpackage

// File: rtl/branch_predictor_bht_sat_counter2.sv
// sat_counter2: combinational next state of a 2-bit saturating
// taken/not-taken counter.
module sat_counter2
  import branch_predictor_bht_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next_c
);

  // Step toward the resolved direction, holding at either end.
  always_comb begin
    ctr_next_c = ctr;
    if (taken) begin
      if (ctr != CTR_ST) ctr_next_c = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_next_c = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht: direct-mapped 2-bit counter predictor with target
// buffer. Predicts for IF_PC, resolves/redirects the branch in EX, and
// trains the table on unstalled EX branches.
// Optional: define PRED_STATS_EN to add Branch_Count/Mispredict_Count.
module branch_predictor_bht
  import branch_predictor_bht_pkg::*;
#(
  parameter int unsigned ENTRIES = BHT_ENTRIES,
  parameter int unsigned TAG_W   = BHT_TAG_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PC_WIDTH-1:0] IF_PC,
  output logic                Pred_Taken,
  output logic [PC_WIDTH-1:0] Pred_Target,
  input  logic                EX_Branch,
  input  logic                EX_Stall,
  input  logic [PC_WIDTH-1:0] EX_PC,
  input  logic                EX_Pred_Taken,
  input  logic [PC_WIDTH-1:0] EX_Pred_Target,
  input  logic                Branch_Taken,
  input  logic [PC_WIDTH-1:0] PC_Plus_Imm,
  output logic                Mispredict,
  output logic [PC_WIDTH-1:0] Redirect_PC
`ifdef PRED_STATS_EN
  ,
  output logic [31:0]         Branch_Count,
  output logic [31:0]         Mispredict_Count
`endif
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  logic                valid_q  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];
  logic [PC_WIDTH-1:0] target_q [ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             if_hit;
  logic             ex_hit;
  logic             pred_taken;
  logic             train;
  logic [1:0]       ctr_next;

  assign if_idx = IF_PC[IDX_W+1:2];
  assign if_tag = IF_PC[IDX_W+TAG_W+1:IDX_W+2];
  assign ex_idx = EX_PC[IDX_W+1:2];
  assign ex_tag = EX_PC[IDX_W+TAG_W+1:IDX_W+2];
  assign train  = EX_Branch && !EX_Stall;

  // IF lookup; reads registered table so a same-cycle write is not bypassed.
  always_comb begin
    if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken  = if_hit && ctr_q[if_idx][1];
    Pred_Taken  = pred_taken;
    Pred_Target = pred_taken ? target_q[if_idx] : IF_PC + PC_WIDTH'(4);
  end

  // EX resolution: flag wrong direction or wrong taken target, steer to actual path.
  always_comb begin
    ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    Redirect_PC = Branch_Taken ? PC_Plus_Imm : EX_PC + PC_WIDTH'(4);
    Mispredict  = EX_Branch &&
                  ((EX_Pred_Taken != Branch_Taken) ||
                   (Branch_Taken && (EX_Pred_Target != PC_Plus_Imm)));
  end

  sat_counter2 u_sat_counter2 (
    .ctr        (ctr_q[ex_idx]),
    .taken      (Branch_Taken),
    .ctr_next_c (ctr_next)
  );

  // Table training: update on hit, allocate on taken miss, ignore not-taken miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        ctr_q[i]    <= CTR_WNT;
        target_q[i] <= '0;
      end
    end else if (train) begin
      if (ex_hit) begin
        ctr_q[ex_idx] <= ctr_next;
        if (Branch_Taken) target_q[ex_idx] <= PC_Plus_Imm;
      end else if (Branch_Taken) begin
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        ctr_q[ex_idx]    <= CTR_WT;
        target_q[ex_idx] <= PC_Plus_Imm;
      end
    end
  end

`ifdef PRED_STATS_EN
  // Free-running training and misprediction counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Branch_Count     <= '0;
      Mispredict_Count <= '0;
    end else if (train) begin
      Branch_Count <= Branch_Count + 32'd1;
      if (Mispredict) Mispredict_Count <= Mispredict_Count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/branch_predictor_bht.md
# branch_predictor_bht

Dynamic branch predictor and redirect unit for the 5-stage RISC-V core. In IF it supplies a taken/not-taken prediction and target for the current fetch PC from a direct-mapped table of 2-bit saturating counters with target buffer. In EX it consumes the branch resolver's Branch_Taken/PC_Plus_Imm, raises Mispredict with the corrected Redirect_PC for the hazard/flush logic, and trains the table.

## Interface
- ENTRIES, 16: table depth, power of 2, ≥2; IDX_W = log2(ENTRIES)
- TAG_W, 8: stored tag width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- IF_PC  in  `PC_WIDTH  current fetch PC
- Pred_Taken  out  1  predicted taken for IF_PC
- Pred_Target  out  `PC_WIDTH  predicted next PC
- EX_Branch  in  1  EX holds a conditional branch
- EX_Stall  in  1  EX stage held; suppresses training
- EX_PC  in  `PC_WIDTH  branch PC in EX
- EX_Pred_Taken  in  1  prediction carried down the pipe with this branch
- EX_Pred_Target  in  `PC_WIDTH  predicted target carried down the pipe
- Branch_Taken  in  1  resolved direction
- PC_Plus_Imm  in  `PC_WIDTH  resolved taken target
- Mispredict  out  1  flush IF/ID and ID/EX, load Redirect_PC
- Redirect_PC  out  `PC_WIDTH  correct next PC
- Branch_Count, Mispredict_Count  out  32  only with PRED_STATS_EN

## Operation
- Index = PC[IDX_W+1:2]; tag = PC[IDX_W+TAG_W+1:IDX_W+2]. Entry = valid, tag, 2-bit counter, target.
- Predict (combinational): hit = valid && tag match; Pred_Taken = hit && ctr[1]; Pred_Target = Pred_Taken ? target : IF_PC+4.
- Resolve (combinational): actual = Branch_Taken ? PC_Plus_Imm : EX_PC+4; Mispredict = EX_Branch && (EX_Pred_Taken != Branch_Taken || (Branch_Taken && EX_Pred_Target != PC_Plus_Imm)); Redirect_PC = actual. Mispredict asserted independent of EX_Stall.
- Train on edge when EX_Branch && !EX_Stall:
  - hit: counter saturating ±1 (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T); if taken, target ← PC_Plus_Imm.
  - miss and taken: allocate/overwrite: valid 1, new tag, target ← PC_Plus_Imm, ctr ← 10.
  - miss and not taken: no write.
- PC adds are modulo 2^`PC_WIDTH.

## Timing
- Prediction and resolution: zero-cycle, combinational; table state changes only at clk edge.
- Same-cycle read/write to one index: IF sees pre-update contents (no bypass).
- EX_Stall held N cycles with a branch: exactly one training write, on the cycle stall deasserts.
- Reset (any time, including mid-update): all valid ← 0, ctr ← 01, target ← 0, counters ← 0. Post-reset outputs: Pred_Taken 0, Pred_Target IF_PC+4, Mispredict 0 unless EX_Branch.

## Configuration
- PRED_STATS_EN defined: Branch_Count increments on every training cycle; Mispredict_Count increments on training cycles with Mispredict; both wrap 0xFFFF_FFFF→0, cleared by reset.
- Undefined: ports and registers absent; all other behaviour identical.

## Structure
- SYSTEM_DEF.vh: `PC_WIDTH, default BHT entries/tag width defines, counter encodings (SNT/WNT/WT/ST).
- One sub-module: sat_counter2 (combinational 2-bit saturating next-state, inputs ctr and taken), instantiated on the training path.

## Test plan
- Reset, IF_PC=0x44 -> Pred_Taken 0, Pred_Target 0x48.
- EX_Branch=1, EX_PC=0x44, Branch_Taken=1, PC_Plus_Imm=0x20, EX_Pred_Taken=0 -> Mispredict 1, Redirect_PC 0x20 same cycle; next cycle IF_PC=0x44 -> Pred_Taken 1, Pred_Target 0x20.
- Hysteresis on 0x44 from ctr 10: NT -> 01 (predict NT); T,T -> 11; NT -> 10 still predicts taken; T with EX_Pred_Target=0x24 vs PC_Plus_Imm 0x20 -> Mispredict 1.
- Alias: EX_PC=0x444 (idx 1, tag 0x11) taken to 0x100 -> IF_PC=0x44 misses (Pred_Target 0x48), IF_PC=0x444 predicts 0x100; not-taken miss at 0x84 -> no allocation.
- EX_Stall=1 for 3 cycles with a taken branch on a ctr-01 entry -> ctr 10 after release, not 11; Branch_Count +1 with PRED_STATS_EN.
- IF_PC=EX_PC=0x44 in training cycle -> Pred_Taken reflects old ctr; async rst_n pulse mid-run -> all lookups miss.
